// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential instruction words from a
// combinational instruction memory into a small circular buffer and presents
// them in program order to the IF stage. A redirect flushes the buffer and
// restarts fetch at a word-aligned address.
module inst_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          WORD      = 64,
    parameter int          INST_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [WORD-1:0]          mem_addr,
    output logic                     mem_en,
    input  logic [INST_SIZE-1:0]     mem_inst,
    input  logic                     redirect,
    input  logic [WORD-1:0]          redirect_pc,
    output logic                     out_valid,
    output logic [INST_SIZE-1:0]     out_inst,
    output logic [WORD-1:0]          out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WORD-1:0]      fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WORD-1:0]      buf_pc_q   [DEPTH];
    logic [INST_SIZE-1:0] buf_inst_q [DEPTH];
    logic                 push;
    logic                 pop;
    logic                 unused_pc_bits;

    // The two low redirect address bits are discarded by the word alignment.
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Handshake decisions; redirect suppresses both push and pop, and the
    // queue never pushes while held in reset.
    always_comb begin
        pop  = (count_q != '0) && out_ready && !redirect;
        push = !rst && !redirect && ((count_q < FULL) || pop);
    end

    // Next-state computation for fetch address, pointers and occupancy.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[WORD-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + 1'b1;
                fetch_pc_d = fetch_pc_q + WORD'(4);
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= WORD'(RESET_PC);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Buffer storage holds data only; it is never reset because out_valid
    // masks any stale entry.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[tail_q]   <= fetch_pc_q;
            buf_inst_q[tail_q] <= mem_inst;
        end
    end

    // Outputs come only from registered state; an empty queue reads as zero.
    always_comb begin
        out_valid = (count_q != '0);
        out_pc    = out_valid ? buf_pc_q[head_q]   : '0;
        out_inst  = out_valid ? buf_inst_q[head_q] : '0;
        mem_addr  = fetch_pc_q;
        mem_en    = push;
        count     = count_q;
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Testbench for inst_prefetch_queue: directed scenarios plus a long random
// run, checked by a queue-based reference model and a negedge monitor.
module tb_inst_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mem_addr;
    logic        mem_en;
    logic [31:0] mem_inst;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: expected queue contents (pcs) and fetch address
    logic [63:0] sb_q [$];
    logic [63:0] fpc        = RPC;
    logic        pend_push  = 1'b0;
    logic        pend_redir = 1'b0;
    logic [63:0] pend_rpc   = '0;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .WORD(64), .INST_SIZE(32)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_en(mem_en), .mem_inst(mem_inst),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    assign mem_inst = mem_addr[31:0] ^ 32'hA5A5_0000;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // apply the effect of the edge that just happened to the model
    task automatic apply_model();
        if (pend_redir) begin
            sb_q.delete();
            fpc = {pend_rpc[63:2], 2'b00};
        end else if (pend_push) begin
            sb_q.push_back(fpc);
            fpc = fpc + 64'd4;
        end
    endtask

    task automatic decide(input logic r, input logic rd, input logic [63:0] rpc);
        logic p;
        out_ready   = r;
        redirect    = rd;
        redirect_pc = rpc;
        pend_redir  = rd;
        pend_rpc    = rpc;
        p           = (sb_q.size() != 0) && r && !rd;
        pend_push   = !rd && ((sb_q.size() < DEPTH) || p);
    endtask

    task automatic step(input logic r, input logic rd, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        apply_model();
        decide(r, rd, rpc);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic r);
        rst = 1'b1;
        out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        sb_q.delete();
        fpc = RPC; pend_push = 1'b0; pend_redir = 1'b0; pend_rpc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        decide(r, 1'b0, 64'h0);
    endtask

    // monitor: compare occupancy every cycle and consume scoreboard entries
    // whenever the DUT hands over its head entry
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 64'(count), 64'(sb_q.size()));
            chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            chk("mem_addr", mem_addr, fpc);
            chk("mem_en", 64'(mem_en), 64'(pend_push));
            if (out_valid && out_ready && !redirect) begin
                if (sb_q.size() == 0) begin
                    chk("pop_on_empty", 64'(out_valid), 64'd0);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    chk("out_pc", out_pc, e);
                    chk("out_inst", 64'(out_inst), 64'(inst_of(e)));
                end
            end
        end
    end

    initial begin
        // state while held in reset
        @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_mem_addr", mem_addr, RPC);

        // streaming with a consumer that is always ready
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 64'h0);
            at_neg();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", out_pc, 64'(4 * i));
        end

        // consumer stalled: queue fills and fetch stops
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0);
        at_neg();
        chk("full_count", 64'(count), 64'd4);
        chk("full_mem_en", 64'(mem_en), 64'd0);
        chk("full_mem_addr", mem_addr, 64'd16);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 64'h0);
            at_neg();
            chk("drain_pc", out_pc, 64'(4 * i));
        end

        // redirect from a full queue with the consumer ready
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0);
        at_neg();
        chk("pre_redir_count", 64'(count), 64'd4);
        step(1'b1, 1'b1, 64'h103);
        at_neg();
        chk("redir_mem_en", 64'(mem_en), 64'd0);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("redir_count", 64'(count), 64'd0);
        chk("redir_valid", 64'(out_valid), 64'd0);
        chk("redir_mem_addr", mem_addr, 64'h100);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("redir_first_valid", 64'(out_valid), 64'd1);
        chk("redir_first_pc", out_pc, 64'h100);

        // back-to-back redirects: the later target wins
        step(1'b1, 1'b1, 64'h200);
        step(1'b1, 1'b1, 64'h300);
        step(1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("dbl_redir_pc0", out_pc, 64'h300);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("dbl_redir_pc1", out_pc, 64'h304);

        // randomized consumer and redirects, including redirects near the
        // top of the address space so the fetch address wraps
        for (int i = 0; i < 10000; i++) begin
            logic        r;
            logic        rd;
            logic [63:0] rpc;
            r  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            else
                rpc = {32'($urandom), 32'($urandom)};
            step(r, rd, rpc);
        end

        // asynchronous reset between clock edges
        step(1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_mem_en", 64'(mem_en), 64'd0);
        chk("async_rst_mem_addr", mem_addr, RPC);
        do_reset(1'b1);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_pc", out_pc, RPC);
        step(1'b1, 1'b0, 64'h0);
        at_neg();
        chk("post_rst_pc1", out_pc, RPC + 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 4, queue entries (power of two, 2..16)
- RESET_PC, 64'h0, fetch address after reset
- WORD, 64, PC width
- INST_SIZE, 32, instruction width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, asynchronous, active-high reset
- mem_addr, out, WORD, instruction memory address; equals fetch_pc
- mem_en, out, 1, high in cycles where the memory word is pushed
- mem_inst, in, INST_SIZE, combinational instruction memory read data for mem_addr
- redirect, in, 1, flush queue and restart fetch at redirect_pc
- redirect_pc, in, WORD, new fetch address
- out_valid, out, 1, head entry valid
- out_inst, out, INST_SIZE, head instruction
- out_pc, out, WORD, head instruction address
- out_ready, in, 1, consumer (IF stage) accepts the head this cycle
- count, out, log2(DEPTH)+1, occupied entries
REQ-003 Clock and reset are decided: one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 Internal state SHALL be fetch_pc (WORD), a DEPTH-entry circular buffer of {pc, inst}, head/tail pointers (log2 DEPTH bits, wrapping modulo DEPTH), and count.
REQ-005 pop SHALL be out_valid && out_ready.
REQ-006 push SHALL be !redirect && (count < DEPTH || pop); mem_en SHALL equal push.
REQ-007 On push: write {fetch_pc, mem_inst} at tail, tail+1, fetch_pc <= fetch_pc + 4 (modulo 2^WORD, wrap from all-ones-minus-3 to 0 allowed).
REQ-008 On pop: head+1.
REQ-009 count update: push&&!pop -> +1; pop&&!push -> -1; both or neither -> unchanged. count SHALL never exceed DEPTH nor underflow.
REQ-010 Full (count==DEPTH) with pop SHALL push in the same cycle (count stays DEPTH); full without pop SHALL not push and fetch_pc SHALL hold.
REQ-011 Empty (count==0): out_valid=0; out_ready ignored; push still allowed.
REQ-012 out_valid SHALL equal (count!=0); out_inst/out_pc SHALL be the head entry, driven from registered storage (no combinational path from mem_inst or redirect to outputs).
REQ-013 redirect SHALL have priority over push and pop: next cycle count=0, head=tail=0, fetch_pc = {redirect_pc[WORD-1:2], 2'b00}; no push and no pop that cycle, even if out_ready=1.
REQ-014 Redirect while full, empty, or on consecutive cycles SHALL behave identically per REQ-013; the last asserted redirect_pc wins.
REQ-015 Latency: an instruction fetched at cycle N SHALL appear at out_* no earlier than cycle N+1; after redirect at N, first out_valid=1 at N+2.
REQ-016 Order SHALL be preserved: out_pc sequence after any redirect is strictly P, P+4, P+8, ...

Reset
REQ-017 While rst=1 (asynchronously on assertion): fetch_pc=RESET_PC, head=tail=0, count=0, out_valid=0, mem_en=0; out_inst/out_pc SHALL read 0. Buffer contents need no reset beyond this.
REQ-018 First push SHALL occur at the first rising edge after rst deasserts; reset mid-operation discards all entries.

Verification
REQ-019 Reset then out_ready=1 constant, mem returns inst=pc[31:0]^32'hA5A5_0000 -> out_valid first high 1 cycle after release, out_pc 0,4,8,... one per cycle, count stays 1.
REQ-020 out_ready=0 for 10 cycles after reset -> count saturates at 4, mem_en=0 and mem_addr=16 once full; then out_ready=1 -> pc 0,4,8,12,16 in order, no gaps.
REQ-021 Full queue, redirect=1 with redirect_pc=64'h103 and out_ready=1 -> next cycle count=0, out_valid=0, mem_addr=64'h100; out_pc=64'h100 two cycles after redirect.
REQ-022 Redirect on two consecutive cycles (0x200 then 0x300) -> only 0x300 stream appears; no 0x200 entry ever valid.
REQ-023 Random out_ready/redirect for 10k cycles against scoreboard model -> no lost, duplicated, or reordered entries; count matches model every cycle.
REQ-024 Assert rst asynchronously mid-stream (between edges) -> out_valid and count drop to 0 immediately; after release fetch restarts at RESET_PC.
